// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared types and sizing helpers for the systolic array feed controller.
//   - ctrl_state_e : controller phase (LOAD, FEED, SETTLE, CAPTURE, OUT)
//   - idx_width    : counter width for an index range 0..n-1 (never below 1 bit)
//   - load_beats   : operand beats per job (all of A followed by all of B)
//   - feed_cycles  : cycles needed to push the skewed operands through the edges
//   - *_CNT_W      : load / feed / out counter widths for the default geometry
// -----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    FEED    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    OUT     = 3'd4
  } ctrl_state_e;

  // Width of a counter indexing 0..n-1; a single-entry range still gets one bit.
  function automatic int idx_width(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

  function automatic int load_beats(input int h, input int w, input int d);
    return (h * d) + (d * w);
  endfunction

  // Last operand pair enters PE(h-1,w-1) at t = (d-1)+(h-1)+(w-1).
  function automatic int feed_cycles(input int h, input int w, input int d);
    return d + h + w - 2;
  endfunction

  localparam int DEF_ARRAY_WIDTH  = 2;
  localparam int DEF_ARRAY_HEIGHT = 2;
  localparam int DEF_DEPTH        = 2;

  localparam int LOAD_CNT_W = idx_width(load_beats(DEF_ARRAY_HEIGHT, DEF_ARRAY_WIDTH, DEF_DEPTH));
  localparam int FEED_CNT_W = idx_width(feed_cycles(DEF_ARRAY_HEIGHT, DEF_ARRAY_WIDTH, DEF_DEPTH));
  localparam int OUT_CNT_W  = idx_width(DEF_ARRAY_HEIGHT * DEF_ARRAY_WIDTH);

endpackage

// File: rtl/systolic_skew_gen.sv
// -----------------------------------------------------------------------------
// systolic_skew_gen
//   Combinational skew map. For feed cycle t, row r carries A[r][t-r] and
//   column c carries B[t-c][c] whenever that inner index lies in 0..depth_p-1.
// Ports
//   t_i          in   feed counter value
//   row_valid_o  out  per-row valid
//   row_k_o      out  per-row inner index k (row r at [r*k_w_p +: k_w_p]), 0 when invalid
//   col_valid_o  out  per-column valid
//   col_k_o      out  per-column inner index k, 0 when invalid
// -----------------------------------------------------------------------------
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2,
  parameter int feed_w_p       = idx_width(feed_cycles(array_height_p, array_width_p, depth_p)),
  parameter int k_w_p          = idx_width(depth_p)
) (
  input  logic [feed_w_p-1:0]               t_i,
  output logic [array_height_p-1:0]         row_valid_o,
  output logic [array_height_p*k_w_p-1:0]   row_k_o,
  output logic [array_width_p-1:0]          col_valid_o,
  output logic [array_width_p*k_w_p-1:0]    col_k_o
);

  int row_diff;
  int col_diff;

  // Row edge: row r lags the feed counter by r cycles.
  always_comb begin
    row_valid_o = {array_height_p{1'b0}};
    row_k_o     = {(array_height_p*k_w_p){1'b0}};
    row_diff    = 0;
    for (int r = 0; r < array_height_p; r++) begin
      row_diff = int'(t_i) - r;
      if ((row_diff >= 0) && (row_diff < depth_p)) begin
        row_valid_o[r]               = 1'b1;
        row_k_o[r*k_w_p +: k_w_p]    = k_w_p'(row_diff);
      end else begin
        row_valid_o[r]               = 1'b0;
        row_k_o[r*k_w_p +: k_w_p]    = {k_w_p{1'b0}};
      end
    end
  end

  // Column edge: column c lags the feed counter by c cycles.
  always_comb begin
    col_valid_o = {array_width_p{1'b0}};
    col_k_o     = {(array_width_p*k_w_p){1'b0}};
    col_diff    = 0;
    for (int c = 0; c < array_width_p; c++) begin
      col_diff = int'(t_i) - c;
      if ((col_diff >= 0) && (col_diff < depth_p)) begin
        col_valid_o[c]               = 1'b1;
        col_k_o[c*k_w_p +: k_w_p]    = k_w_p'(col_diff);
      end else begin
        col_valid_o[c]               = 1'b0;
        col_k_o[c*k_w_p +: k_w_p]    = {k_w_p{1'b0}};
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_feed_ctrl
//   Sequencer in front of an output-stationary systolic array.
//   LOAD    : accept A (row-major) then B (row-major) on valid_i/ready_o.
//   FEED    : drive skewed operands on the row/column edges for T cycles.
//   SETTLE  : one idle cycle while the last product lands in PE(h-1,w-1).
//   CAPTURE : latch z_i and pulse array_clear_o.
//   OUT     : stream C row-major on valid_o/yumi_i, then back to LOAD.
// Ports
//   clk_i, reset_i (async, active-low), en_i (0 freezes everything)
//   valid_i/ready_o/data_i      operand stream
//   row_data_o/row_valid_o      A edge, row r at [r*width_p +: width_p]
//   col_data_o/col_valid_o      B edge, column c at [c*width_p +: width_p]
//   array_en_o, array_clear_o   array clock enable and accumulator clear
//   z_i                         array results, PE(r,c) at index r*array_width_p+c
//   valid_o/yumi_i/data_o       result stream
// -----------------------------------------------------------------------------
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int acc_width_p    = 16,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic                                              valid_i,
  output logic                                              ready_o,
  input  logic [width_p-1:0]                                data_i,
  output logic [array_height_p*width_p-1:0]                 row_data_o,
  output logic [array_height_p-1:0]                         row_valid_o,
  output logic [array_width_p*width_p-1:0]                  col_data_o,
  output logic [array_width_p-1:0]                          col_valid_o,
  output logic                                              array_en_o,
  output logic                                              array_clear_o,
  input  logic [array_height_p*array_width_p*acc_width_p-1:0] z_i,
  output logic                                              valid_o,
  input  logic                                              yumi_i,
  output logic [acc_width_p-1:0]                            data_o
);

  localparam int H     = array_height_p;
  localparam int W     = array_width_p;
  localparam int D     = depth_p;
  localparam int NA    = H * D;                 // A occupies op slots 0..NA-1
  localparam int NLOAD = load_beats(H, W, D);
  localparam int NFEED = feed_cycles(H, W, D);
  localparam int NOUT  = H * W;
  localparam int LW    = idx_width(NLOAD);
  localparam int FW    = idx_width(NFEED);
  localparam int OW    = idx_width(NOUT);
  localparam int KW    = idx_width(D);

  ctrl_state_e state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [FW-1:0] t_q, t_d;
  logic [OW-1:0] out_idx_q, out_idx_d;

  // Single operand buffer: A[r][k] at r*D+k, B[k][c] at NA+k*W+c.
  logic [width_p-1:0]     op_q  [NLOAD];
  logic [width_p-1:0]     op_d  [NLOAD];
  logic [acc_width_p-1:0] res_q [NOUT];
  logic [acc_width_p-1:0] res_d [NOUT];

  logic [H*width_p-1:0]   row_data_q, row_data_d;
  logic [H-1:0]           row_valid_q, row_valid_d;
  logic [W*width_p-1:0]   col_data_q, col_data_d;
  logic [W-1:0]           col_valid_q, col_valid_d;
  logic                   clear_q, clear_d;
  logic [acc_width_p-1:0] data_q, data_d;

  logic [H-1:0]           row_v;
  logic [H*KW-1:0]        row_k;
  logic [W-1:0]           col_v;
  logic [W*KW-1:0]        col_k;

  // Skew is evaluated for the next feed count so the edge registers present
  // cycle-t values during cycle t of FEED.
  systolic_skew_gen #(
    .array_width_p  (W),
    .array_height_p (H),
    .depth_p        (D),
    .feed_w_p       (FW),
    .k_w_p          (KW)
  ) u_skew (
    .t_i         (t_d),
    .row_valid_o (row_v),
    .row_k_o     (row_k),
    .col_valid_o (col_v),
    .col_k_o     (col_k)
  );

  // Next-state, counters and buffer writes; en_i=0 leaves everything as is.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    out_idx_d  = out_idx_q;
    op_d       = op_q;
    res_d      = res_q;
    if (en_i) begin
      case (state_q)
        LOAD: begin
          if (valid_i) begin
            op_d[load_cnt_q] = data_i;
            if (load_cnt_q == LW'(NLOAD - 1)) begin
              load_cnt_d = {LW{1'b0}};
              t_d        = {FW{1'b0}};
              state_d    = FEED;
            end else begin
              load_cnt_d = load_cnt_q + LW'(1);
            end
          end else begin
            load_cnt_d = load_cnt_q;
          end
        end
        FEED: begin
          if (t_q == FW'(NFEED - 1)) begin
            t_d     = {FW{1'b0}};
            state_d = SETTLE;
          end else begin
            t_d     = t_q + FW'(1);
          end
        end
        SETTLE: begin
          state_d = CAPTURE;
        end
        CAPTURE: begin
          for (int i = 0; i < NOUT; i++) begin
            res_d[i] = z_i[i*acc_width_p +: acc_width_p];
          end
          out_idx_d = {OW{1'b0}};
          state_d   = OUT;
        end
        OUT: begin
          if (yumi_i) begin
            if (out_idx_q == OW'(NOUT - 1)) begin
              out_idx_d = {OW{1'b0}};
              state_d   = LOAD;
            end else begin
              out_idx_d = out_idx_q + OW'(1);
            end
          end else begin
            out_idx_d = out_idx_q;
          end
        end
        default: begin
          state_d    = LOAD;
          load_cnt_d = {LW{1'b0}};
          t_d        = {FW{1'b0}};
          out_idx_d  = {OW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Registered edge/result outputs for the coming cycle. Reading op_d/res_d
  // lets the final load beat and the capture feed straight through.
  always_comb begin
    row_data_d  = row_data_q;
    row_valid_d = row_valid_q;
    col_data_d  = col_data_q;
    col_valid_d = col_valid_q;
    clear_d     = clear_q;
    data_d      = data_q;
    if (en_i) begin
      for (int r = 0; r < H; r++) begin
        if ((state_d == FEED) && row_v[r]) begin
          row_valid_d[r]                     = 1'b1;
          row_data_d[r*width_p +: width_p]   = op_d[LW'(r*D + int'(row_k[r*KW +: KW]))];
        end else begin
          row_valid_d[r]                     = 1'b0;
          row_data_d[r*width_p +: width_p]   = {width_p{1'b0}};
        end
      end
      for (int c = 0; c < W; c++) begin
        if ((state_d == FEED) && col_v[c]) begin
          col_valid_d[c]                     = 1'b1;
          col_data_d[c*width_p +: width_p]   = op_d[LW'(NA + int'(col_k[c*KW +: KW])*W + c)];
        end else begin
          col_valid_d[c]                     = 1'b0;
          col_data_d[c*width_p +: width_p]   = {width_p{1'b0}};
        end
      end
      clear_d = (state_d == CAPTURE);
      if (state_d == OUT) begin
        data_d = res_d[out_idx_d];
      end else begin
        data_d = {acc_width_p{1'b0}};
      end
    end else begin
      clear_d = clear_q;
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= LOAD;
      load_cnt_q  <= {LW{1'b0}};
      t_q         <= {FW{1'b0}};
      out_idx_q   <= {OW{1'b0}};
      row_data_q  <= {(H*width_p){1'b0}};
      row_valid_q <= {H{1'b0}};
      col_data_q  <= {(W*width_p){1'b0}};
      col_valid_q <= {W{1'b0}};
      clear_q     <= 1'b0;
      data_q      <= {acc_width_p{1'b0}};
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      t_q         <= t_d;
      out_idx_q   <= out_idx_d;
      row_data_q  <= row_data_d;
      row_valid_q <= row_valid_d;
      col_data_q  <= col_data_d;
      col_valid_q <= col_valid_d;
      clear_q     <= clear_d;
      data_q      <= data_d;
    end
  end

  // Operand and result storage; contents after reset are don't-care.
  always_ff @(posedge clk_i) begin
    op_q  <= op_d;
    res_q <= res_d;
  end

  // Handshakes are refused while frozen, so ready/valid qualify with en_i.
  assign ready_o       = en_i & (state_q == LOAD);
  assign valid_o       = en_i & (state_q == OUT);
  assign array_en_o    = en_i;
  assign array_clear_o = clear_q;
  assign row_data_o    = row_data_q;
  assign row_valid_o   = row_valid_q;
  assign col_data_o    = col_data_q;
  assign col_valid_o   = col_valid_q;
  assign data_o        = data_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
module tb_systolic_feed_ctrl;

  localparam int WD  = 8;
  localparam int ACC = 16;
  localparam int AW  = 2;
  localparam int AH  = 2;
  localparam int D   = 2;

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic                   en_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [WD-1:0]          data_i;
  logic [AH*WD-1:0]       row_data_o;
  logic [AH-1:0]          row_valid_o;
  logic [AW*WD-1:0]       col_data_o;
  logic [AW-1:0]          col_valid_o;
  logic                   array_en_o;
  logic                   array_clear_o;
  logic [AH*AW*ACC-1:0]   z_i;
  logic                   valid_o;
  logic                   yumi_i;
  logic [ACC-1:0]         data_o;

  int checks   = 0;
  int failures = 0;

  logic [ACC-1:0] exp_q[$];
  logic [WD-1:0]  ma [AH][D];
  logic [WD-1:0]  mb [D][AW];

  systolic_feed_ctrl #(
    .width_p(WD), .acc_width_p(ACC), .array_width_p(AW),
    .array_height_p(AH), .depth_p(D)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_i(data_i), .row_data_o(row_data_o),
    .row_valid_o(row_valid_o), .col_data_o(col_data_o), .col_valid_o(col_valid_o),
    .array_en_o(array_en_o), .array_clear_o(array_clear_o), .z_i(z_i),
    .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural output-stationary systolic array driven by the DUT edges.
  logic [WD-1:0]  pa [AH][AW];
  logic [WD-1:0]  pb [AH][AW];
  logic           va [AH][AW];
  logic           vb [AH][AW];
  logic [ACC-1:0] acc [AH][AW];
  logic [WD-1:0]  ia [AH][AW];
  logic [WD-1:0]  ib [AH][AW];
  logic           iva [AH][AW];
  logic           ivb [AH][AW];

  always_comb begin
    for (int r = 0; r < AH; r++) begin
      ia[r][0]  = row_data_o[r*WD +: WD];
      iva[r][0] = row_valid_o[r];
      for (int c = 1; c < AW; c++) begin
        ia[r][c]  = pa[r][c-1];
        iva[r][c] = va[r][c-1];
      end
    end
    for (int c = 0; c < AW; c++) begin
      ib[0][c]  = col_data_o[c*WD +: WD];
      ivb[0][c] = col_valid_o[c];
      for (int r = 1; r < AH; r++) begin
        ib[r][c]  = pb[r-1][c];
        ivb[r][c] = vb[r-1][c];
      end
    end
    for (int r = 0; r < AH; r++) begin
      for (int c = 0; c < AW; c++) begin
        z_i[(r*AW+c)*ACC +: ACC] = acc[r][c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int r = 0; r < AH; r++) begin
        for (int c = 0; c < AW; c++) begin
          pa[r][c] <= '0; pb[r][c] <= '0; va[r][c] <= 1'b0; vb[r][c] <= 1'b0; acc[r][c] <= '0;
        end
      end
    end else if (array_en_o) begin
      for (int r = 0; r < AH; r++) begin
        for (int c = 0; c < AW; c++) begin
          if (array_clear_o) begin
            pa[r][c] <= '0; pb[r][c] <= '0; va[r][c] <= 1'b0; vb[r][c] <= 1'b0; acc[r][c] <= '0;
          end else begin
            pa[r][c] <= ia[r][c];
            pb[r][c] <= ib[r][c];
            va[r][c] <= iva[r][c];
            vb[r][c] <= ivb[r][c];
            if (iva[r][c] && ivb[r][c]) begin
              acc[r][c] <= acc[r][c] + ACC'(ia[r][c]) * ACC'(ib[r][c]);
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Matrices given as packed row-major bytes, element 0 in the top byte.
  task automatic set_mats(input logic [AH*D*WD-1:0] a, input logic [D*AW*WD-1:0] b);
    for (int r = 0; r < AH; r++)
      for (int k = 0; k < D; k++)
        ma[r][k] = a[(AH*D-1-(r*D+k))*WD +: WD];
    for (int k = 0; k < D; k++)
      for (int c = 0; c < AW; c++)
        mb[k][c] = b[(D*AW-1-(k*AW+c))*WD +: WD];
  endtask

  // Drive all operand beats and queue the reference product.
  task automatic load_operands();
    logic [ACC-1:0] s;
    int n;
    for (int r = 0; r < AH; r++) begin
      for (int c = 0; c < AW; c++) begin
        s = '0;
        for (int k = 0; k < D; k++) s = s + ACC'(ma[r][k]) * ACC'(mb[k][c]);
        exp_q.push_back(s);
      end
    end
    for (int i = 0; i < AH*D + D*AW; i++) begin
      valid_i = 1'b1;
      if (i < AH*D) data_i = ma[i / D][i % D];
      else          data_i = mb[(i - AH*D) / AW][(i - AH*D) % AW];
      n = 0;
      while (!ready_o && n < 50) begin
        tick();
        n++;
      end
      check("load_ready", ready_o, 1'b1);
      tick();
    end
    valid_i = 1'b0;
  endtask

  // Consume results: yumi every 'period' cycles, optional junk valid_i, stop after maxpop.
  task automatic drain(input int period, input logic junk, input int maxpop);
    int  pops;
    int  cyc;
    logic hs;
    pops = 0;
    cyc  = 0;
    while (exp_q.size() > 0 && pops < maxpop && cyc < 200) begin
      cyc++;
      yumi_i  = ((cyc % period) == 0);
      valid_i = junk;
      data_i  = 8'hFF;
      hs      = valid_o && yumi_i;
      if (valid_o) begin
        check("out_ready_low", ready_o, 1'b0);
        if (yumi_i) check("out_data", data_o, exp_q[0]);
        else        check("out_hold", data_o, exp_q[0]);
      end
      tick();
      if (hs) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    yumi_i  = 1'b0;
    valid_i = 1'b0;
    check("drain_progress", (pops >= maxpop) || (exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    reset_i = 1'b0;
    en_i    = 1'b1;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    tick();
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_row_valid", row_valid_o, 2'b00);
    check("rst_col_valid", col_valid_o, 2'b00);
    check("rst_clear", array_clear_o, 1'b0);
    check("rst_data", data_o, 16'h0000);
    check("rst_array_en", array_en_o, 1'b1);

    // 1: skew pattern and full run
    set_mats(32'h01020304, 32'h01020304);
    load_operands();
    check("feed_ready_low", ready_o, 1'b0);
    check("t0_row_valid", row_valid_o, 2'b01);
    check("t0_row_data", row_data_o, 16'h0001);
    check("t0_col_valid", col_valid_o, 2'b01);
    check("t0_col_data", col_data_o, 16'h0001);
    tick();
    check("t1_row_valid", row_valid_o, 2'b11);
    check("t1_row_data", row_data_o, 16'h0302);
    check("t1_col_valid", col_valid_o, 2'b11);
    check("t1_col_data", col_data_o, 16'h0203);
    tick();
    check("t2_row_valid", row_valid_o, 2'b10);
    check("t2_row_data", row_data_o, 16'h0400);
    check("t2_col_valid", col_valid_o, 2'b10);
    check("t2_col_data", col_data_o, 16'h0400);
    tick();
    check("t3_row_valid", row_valid_o, 2'b00);
    check("t3_col_valid", col_valid_o, 2'b00);
    check("t3_row_data", row_data_o, 16'h0000);
    tick();
    check("settle_row_valid", row_valid_o, 2'b00);
    check("settle_clear", array_clear_o, 1'b0);
    check("settle_valid", valid_o, 1'b0);
    tick();
    check("capture_clear", array_clear_o, 1'b1);
    check("capture_valid", valid_o, 1'b0);
    tick();
    check("out_clear_low", array_clear_o, 1'b0);
    check("out_valid", valid_o, 1'b1);
    drain(1, 1'b0, 100);
    check("run1_back_ready", ready_o, 1'b1);
    check("run1_back_valid", valid_o, 1'b0);

    // 2 and 3: yumi held, then yumi every third cycle
    load_operands();
    drain(1, 1'b0, 100);
    load_operands();
    drain(3, 1'b0, 100);
    check("bp_back_ready", ready_o, 1'b1);

    // 4: junk valid_i during FEED/OUT, then a different product
    load_operands();
    drain(1, 1'b1, 100);
    check("junk_back_ready", ready_o, 1'b1);
    set_mats(32'h02000103, 32'h05060708);
    load_operands();
    drain(1, 1'b0, 100);

    // 5: freeze mid-FEED
    set_mats(32'h01020304, 32'h01020304);
    load_operands();
    tick();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_row_data", row_data_o, 16'h0302);
      check("frz_row_valid", row_valid_o, 2'b11);
      check("frz_col_data", col_data_o, 16'h0203);
      check("frz_array_en", array_en_o, 1'b0);
      check("frz_ready", ready_o, 1'b0);
    end
    en_i = 1'b1;
    tick();
    check("unfrz_row_data", row_data_o, 16'h0400);
    check("unfrz_col_valid", col_valid_o, 2'b10);
    drain(1, 1'b0, 100);

    // 6: reset during OUT after two results
    load_operands();
    drain(1, 1'b0, 2);
    check("pre_rst_valid", valid_o, 1'b1);
    reset_i = 1'b0;
    #1;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_data", data_o, 16'h0000);
    exp_q.delete();
    tick();
    reset_i = 1'b1;
    tick();
    check("postrst_ready", ready_o, 1'b1);
    check("postrst_valid", valid_o, 1'b0);
    set_mats(32'h02000103, 32'h05060708);
    load_operands();
    drain(1, 1'b0, 100);
    check("final_ready", ready_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
